// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost movement pipeline.
package ghost_pkg;

    // Maze dimensions in tiles
    localparam int C_MAZE_COLS = 28;
    localparam int C_MAZE_ROWS = 31;

    // Headings as produced by the behaviour/targeting stage
    typedef enum logic [1:0] {
        DIR_U = 2'b00,
        DIR_R = 2'b01,
        DIR_D = 2'b10,
        DIR_L = 2'b11
    } dir_t;

    // Mover FSM states
    typedef enum logic {
        ST_CENTER = 1'b0,
        ST_STEP   = 1'b1
    } mover_state_t;

    // Opposite heading: flipping the MSB swaps U<->D and R<->L
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

    // Look up the wall-free flag for a heading
    function automatic logic is_open(input dir_t d, input logic u,
                                     input logic r, input logic dn,
                                     input logic l);
        logic res;
        case (d)
            DIR_U:   res = u;
            DIR_R:   res = r;
            DIR_D:   res = dn;
            default: res = l;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ghost_mover_tile_step.sv
// Combinational one-tile advance in a given heading, with
// horizontal wrap-around on the tunnel row.
module tile_step
    import ghost_pkg::*;
#(
    parameter int X_WIDTH   = 5,
    parameter int Y_WIDTH   = 5,
    parameter int MAZE_COLS = C_MAZE_COLS
) (
    input  logic [X_WIDTH-1:0] i_x,
    input  logic [Y_WIDTH-1:0] i_y,
    input  logic [1:0]         i_dir,
    input  logic               i_tunnel,
    output logic [X_WIDTH-1:0] o_x,
    output logic [Y_WIDTH-1:0] o_y
);

    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(MAZE_COLS - 1);
    localparam logic [X_WIDTH-1:0] X_ONE  = X_WIDTH'(1);
    localparam logic [Y_WIDTH-1:0] Y_ONE  = Y_WIDTH'(1);

    // Neighbour tile coordinate; walls keep non-tunnel rows in range
    always_comb begin
        o_x = i_x;
        o_y = i_y;
        case (dir_t'(i_dir))
            DIR_U: o_y = i_y - Y_ONE;
            DIR_D: o_y = i_y + Y_ONE;
            DIR_R: begin
                if (i_tunnel && (i_x == X_LAST)) o_x = '0;
                else                             o_x = i_x + X_ONE;
            end
            default: begin
                if (i_tunnel && (i_x == '0)) o_x = X_LAST;
                else                         o_x = i_x - X_ONE;
            end
        endcase
    end

endmodule

// File: rtl/ghost_mover.sv
// Ghost mover: turns heading decisions and wall flags into sub-tile
// motion through the maze, publishing tile position and heading.
module ghost_mover
    import ghost_pkg::*;
#(
    parameter int X_WIDTH        = 5,
    parameter int Y_WIDTH        = 5,
    parameter int MAZE_COLS      = C_MAZE_COLS,
    parameter int STEPS_PER_TILE = 8,
    parameter int START_X        = 13,
    parameter int START_Y        = 11,
    parameter int TUNNEL_ROW     = 14
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              moveTick,
    input  logic [1:0]                        dirToMove,
    input  logic                              canMoveU,
    input  logic                              canMoveR,
    input  logic                              canMoveD,
    input  logic                              canMoveL,
    input  logic                              forceReverse,
    output logic [X_WIDTH-1:0]                ghostPosX,
    output logic [Y_WIDTH-1:0]                ghostPosY,
    output logic [$clog2(STEPS_PER_TILE)-1:0] subStep,
    output logic [1:0]                        curDir,
    output logic                              atCenter,
    output logic                              stalled
);

    localparam int SUB_W = $clog2(STEPS_PER_TILE);
    localparam logic [SUB_W-1:0]   SUB_LAST = SUB_W'(STEPS_PER_TILE - 1);
    localparam logic [SUB_W-1:0]   SUB_ONE  = SUB_W'(1);
    localparam logic [X_WIDTH-1:0] X_START  = X_WIDTH'(START_X);
    localparam logic [Y_WIDTH-1:0] Y_START  = Y_WIDTH'(START_Y);
    localparam logic [Y_WIDTH-1:0] Y_TUNNEL = Y_WIDTH'(TUNNEL_ROW);

    mover_state_t       r_state,   w_state_nxt;
    logic [X_WIDTH-1:0] r_x,       w_x_nxt;
    logic [Y_WIDTH-1:0] r_y,       w_y_nxt;
    logic [SUB_W-1:0]   r_sub,     w_sub_nxt;
    dir_t               r_dir,     w_dir_nxt;
    logic               r_stalled, w_stalled_nxt;
    logic               r_rev,     w_rev_nxt;
    logic               r_at_center;

    logic               w_tick;
    logic               w_rev_eff;
    logic               w_go;
    dir_t               w_opp;
    dir_t               w_req;
    logic [X_WIDTH-1:0] w_step_x;
    logic [Y_WIDTH-1:0] w_step_y;

    assign w_tick = enable & moveTick;
    assign w_opp  = opposite(r_dir);
    assign w_req  = dir_t'(dirToMove);

    tile_step #(
        .X_WIDTH   (X_WIDTH),
        .Y_WIDTH   (Y_WIDTH),
        .MAZE_COLS (MAZE_COLS)
    ) u_tile_step (
        .i_x      (r_x),
        .i_y      (r_y),
        .i_dir    (r_dir),
        .i_tunnel (r_y == Y_TUNNEL),
        .o_x      (w_step_x),
        .o_y      (w_step_y)
    );

    // State, position and heading registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_CENTER;
            r_x         <= X_START;
            r_y         <= Y_START;
            r_sub       <= '0;
            r_dir       <= DIR_L;
            r_stalled   <= 1'b0;
            r_rev       <= 1'b0;
            r_at_center <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_sub       <= w_sub_nxt;
            r_dir       <= w_dir_nxt;
            r_stalled   <= w_stalled_nxt;
            r_rev       <= w_rev_nxt;
            r_at_center <= (w_state_nxt == ST_CENTER);
        end
    end

    // Next-state: heading decision at centre, sub-tile advance in STEP
    always_comb begin
        w_state_nxt   = r_state;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_sub_nxt     = r_sub;
        w_dir_nxt     = r_dir;
        w_stalled_nxt = r_stalled;
        // A reversal request is remembered even while frozen
        w_rev_nxt     = r_rev | forceReverse;
        w_rev_eff     = r_rev | forceReverse;
        w_go          = 1'b0;

        if (w_tick) begin
            case (r_state)
                ST_CENTER: begin
                    // A pulse arriving on the deciding tick takes effect at once
                    if (w_rev_eff &&
                        is_open(w_opp, canMoveU, canMoveR, canMoveD, canMoveL)) begin
                        w_dir_nxt = w_opp;
                        w_rev_nxt = 1'b0;
                        w_go      = 1'b1;
                    end else if (is_open(w_req, canMoveU, canMoveR, canMoveD, canMoveL)) begin
                        w_dir_nxt = w_req;
                        w_go      = 1'b1;
                    end else if (is_open(r_dir, canMoveU, canMoveR, canMoveD, canMoveL)) begin
                        w_go      = 1'b1;
                    end else begin
                        w_stalled_nxt = 1'b1;
                    end
                    if (w_go) begin
                        w_stalled_nxt = 1'b0;
                        w_sub_nxt     = SUB_ONE;
                        w_state_nxt   = ST_STEP;
                    end
                end
                default: begin
                    if (r_sub == SUB_LAST) begin
                        w_sub_nxt   = '0;
                        w_x_nxt     = w_step_x;
                        w_y_nxt     = w_step_y;
                        w_state_nxt = ST_CENTER;
                    end else begin
                        w_sub_nxt   = r_sub + SUB_ONE;
                    end
                end
            endcase
        end
    end

    assign ghostPosX = r_x;
    assign ghostPosY = r_y;
    assign subStep   = r_sub;
    assign curDir    = r_dir;
    assign atCenter  = r_at_center;
    assign stalled   = r_stalled;

endmodule

// File: tb/tb_ghost_mover.sv
// Directed bench for ghost_mover with hand-computed expectations.
module tb_ghost_mover;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       moveTick = 1'b0;
    logic [1:0] dirToMove = 2'b11;
    logic       canMoveU = 1'b0;
    logic       canMoveR = 1'b0;
    logic       canMoveD = 1'b0;
    logic       canMoveL = 1'b0;
    logic       forceReverse = 1'b0;
    logic [4:0] ghostPosX;
    logic [4:0] ghostPosY;
    logic [2:0] subStep;
    logic [1:0] curDir;
    logic       atCenter;
    logic       stalled;

    int n_cmp = 0;
    int n_err = 0;

    ghost_mover #(
        .X_WIDTH        (5),
        .Y_WIDTH        (5),
        .MAZE_COLS      (28),
        .STEPS_PER_TILE (8),
        .START_X        (13),
        .START_Y        (11),
        .TUNNEL_ROW     (14)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .moveTick     (moveTick),
        .dirToMove    (dirToMove),
        .canMoveU     (canMoveU),
        .canMoveR     (canMoveR),
        .canMoveD     (canMoveD),
        .canMoveL     (canMoveL),
        .forceReverse (forceReverse),
        .ghostPosX    (ghostPosX),
        .ghostPosY    (ghostPosY),
        .subStep      (subStep),
        .curDir       (curDir),
        .atCenter     (atCenter),
        .stalled      (stalled)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change #1 after a rising edge; outputs are read at the same point
    task automatic tick();
        moveTick = 1'b1;
        @(posedge clk); #1;
        moveTick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic walls(input logic u, input logic r, input logic d, input logic l);
        canMoveU = u; canMoveR = r; canMoveD = d; canMoveL = l;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic chk_pos(input string tag, input int x, input int y);
        chk({tag, "_x"}, 32'(ghostPosX), 32'(x));
        chk({tag, "_y"}, 32'(ghostPosY), 32'(y));
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        do_reset();
        chk_pos("rst", 13, 11);
        chk("rst_sub", 32'(subStep), 0);
        chk("rst_dir", 32'(curDir), 3);
        chk("rst_atc", 32'(atCenter), 1);
        chk("rst_stall", 32'(stalled), 0);

        // One tile left: eight ticks
        dirToMove = 2'b11; walls(0, 0, 0, 1);
        tick();
        chk("t1_atc", 32'(atCenter), 0);
        chk("t1_sub", 32'(subStep), 1);
        ticks(6);
        chk("t7_sub", 32'(subStep), 7);
        chk("t7_atc", 32'(atCenter), 0);
        chk("t7_x", 32'(ghostPosX), 13);
        tick();
        chk_pos("t8", 12, 11);
        chk("t8_dir", 32'(curDir), 3);
        chk("t8_atc", 32'(atCenter), 1);
        chk("t8_sub", 32'(subStep), 0);

        // Requested U blocked: keep going L
        dirToMove = 2'b00; walls(0, 0, 0, 1);
        tick();
        chk("blkU_dir", 32'(curDir), 3);
        chk("blkU_atc", 32'(atCenter), 0);
        ticks(7);
        chk_pos("blkU", 11, 11);

        // All walls closed: stall in place
        walls(0, 0, 0, 0);
        ticks(3);
        chk("stall_flag", 32'(stalled), 1);
        chk_pos("stall", 11, 11);
        chk("stall_atc", 32'(atCenter), 1);
        chk("stall_dir", 32'(curDir), 3);

        // Walk down to the tunnel row, then left to the edge
        dirToMove = 2'b10; walls(0, 0, 1, 0);
        ticks(24);
        chk_pos("down", 11, 14);
        chk("down_dir", 32'(curDir), 2);
        chk("down_stall", 32'(stalled), 0);
        dirToMove = 2'b11; walls(0, 0, 0, 1);
        ticks(88);
        chk_pos("edgeL", 0, 14);

        // Tunnel wrap both ways
        ticks(8);
        chk_pos("wrapL", 27, 14);
        dirToMove = 2'b01; walls(0, 1, 0, 0);
        ticks(8);
        chk_pos("wrapR", 0, 14);
        chk("wrapR_dir", 32'(curDir), 1);

        // Reversal requested mid-tile waits for the centre
        dirToMove = 2'b01; walls(0, 1, 0, 1);
        ticks(3);
        chk("rev_sub3", 32'(subStep), 3);
        forceReverse = 1'b1;
        @(posedge clk); #1;
        forceReverse = 1'b0;
        chk("rev_hold_dir", 32'(curDir), 1);
        chk("rev_hold_sub", 32'(subStep), 3);
        ticks(5);
        chk_pos("rev_ctr", 1, 14);
        chk("rev_ctr_dir", 32'(curDir), 1);
        tick();
        chk("rev_apply_dir", 32'(curDir), 3);
        ticks(7);
        chk_pos("rev_back", 0, 14);

        // Freeze mid-step; a reversal pulse while frozen is still latched
        dirToMove = 2'b11; walls(0, 0, 0, 1);
        ticks(3);
        enable = 1'b0;
        forceReverse = 1'b1;
        @(posedge clk); #1;
        forceReverse = 1'b0;
        ticks(5);
        chk("frz_sub", 32'(subStep), 3);
        chk("frz_x", 32'(ghostPosX), 0);
        chk("frz_atc", 32'(atCenter), 0);
        enable = 1'b1;
        ticks(5);
        chk_pos("frz_done", 27, 14);
        chk("frz_done_atc", 32'(atCenter), 1);
        walls(0, 1, 0, 1);
        tick();
        chk("frz_rev_dir", 32'(curDir), 1);
        ticks(4);
        chk("pre_rst_sub", 32'(subStep), 5);

        // Reset mid-step discards the partial move
        do_reset();
        chk_pos("mrst", 13, 11);
        chk("mrst_sub", 32'(subStep), 0);
        chk("mrst_dir", 32'(curDir), 3);
        chk("mrst_atc", 32'(atCenter), 1);

        // Reversal pulse on the deciding tick applies immediately
        dirToMove = 2'b00; walls(1, 1, 1, 1);
        forceReverse = 1'b1;
        tick();
        forceReverse = 1'b0;
        chk("same_rev_dir", 32'(curDir), 1);

        // Blocked reversal falls through and stays pending
        do_reset();
        forceReverse = 1'b1;
        @(posedge clk); #1;
        forceReverse = 1'b0;
        dirToMove = 2'b00; walls(1, 0, 0, 1);
        tick();
        chk("fall_dir", 32'(curDir), 0);
        ticks(7);
        chk_pos("fall", 13, 10);
        dirToMove = 2'b11; walls(0, 0, 1, 1);
        tick();
        chk("pend_dir", 32'(curDir), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ghost_mover.md
Name: ghost_mover

Overview:
- Downstream stage of each ghost's behaviour/targeting logic.
- Consumes the 2-bit direction decision and the wall flags for the current tile, and advances the ghost through the maze one sub-tile step per movement tick.
- Publishes the ghost's tile position and heading. These feed back into the behaviour stage as ghostPosX/ghostPosY and also drive the sprite renderer.

Parameters:
- X_WIDTH, 5, width of tile X coordinate
- Y_WIDTH, 5, width of tile Y coordinate
- MAZE_COLS, 28, number of tile columns (X range 0..27)
- STEPS_PER_TILE, 8, sub-tile steps per tile; must be a power of 2, at least 2
- START_X, 13, reset tile X
- START_Y, 11, reset tile Y
- TUNNEL_ROW, 14, only row on which horizontal wrap-around is legal

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  0 freezes all movement; ticks are ignored
- moveTick  in  1  single-cycle pulse; one sub-tile step per pulse
- dirToMove  in  2  requested heading: 00 U, 01 R, 10 D, 11 L
- canMoveU, canMoveR, canMoveD, canMoveL  in  1 each  wall-free neighbour flags for the current tile
- forceReverse  in  1  single-cycle pulse (mode change); requests a reversal at the next tile centre
- ghostPosX  out  X_WIDTH  current tile X
- ghostPosY  out  Y_WIDTH  current tile Y
- subStep  out  $clog2(STEPS_PER_TILE)  offset from tile centre along curDir
- curDir  out  2  current heading
- atCenter  out  1  1 while the ghost is at a tile centre (CENTER state)
- stalled  out  1  1 if the last centre decision found no legal move

Behaviour:
- Reset values (sync): ghostPosX=START_X, ghostPosY=START_Y, subStep=0, curDir=11 (L), state=CENTER, atCenter=1, stalled=0, revPending=0.
- FSM has two states, CENTER and STEP. All outputs are registered.
- Ticks only count when enable=1. When enable=0, no state, position, or subStep change occurs. forceReverse is still latched into revPending.
- CENTER, on a counted tick, decide the heading in priority order:
  1. If revPending=1 and the opposite of curDir is open: curDir <= opposite; clear revPending.
  2. Else if dirToMove is open: curDir <= dirToMove.
  3. Else if curDir is open: keep curDir.
  4. Else: stalled <= 1; stay in CENTER with curDir unchanged.
- "Open" means the canMove flag for that direction is 1.
- In cases 1–3: stalled <= 0; subStep <= 1; go to STEP. atCenter falls in that same cycle.
- If revPending=1 but the opposite direction is blocked, revPending stays set and the rule falls through to step 2.
- dirToMove and the canMove flags are sampled only in CENTER on a counted tick. They are don't-care at all other times.
- STEP, on a counted tick: subStep increments.
  - When subStep = STEPS_PER_TILE-1, the tick instead sets subStep <= 0, steps the tile coordinate one tile in curDir, and returns to CENTER.
  - This makes one tile take exactly STEPS_PER_TILE counted ticks.
- Tile arithmetic:
  - U: Y-1. D: Y+1. R: X+1. L: X-1.
  - On TUNNEL_ROW: X=0 moving L gives MAZE_COLS-1, and X=MAZE_COLS-1 moving R gives 0.
  - Off the tunnel row, the walls guarantee no edge crossing, so no clamp logic is required.
- A forceReverse that arrives while already pending is idempotent. A forceReverse and a counted tick in the same cycle in CENTER: the reversal is applied on that same tick.
- Asserting reset mid-STEP returns to the reset values on the next edge. No partial move is committed.

Decomposition:
- ghost_pkg holds:
  - dir_t enum (DIR_U=2'b00, DIR_R=2'b01, DIR_D=2'b10, DIR_L=2'b11)
  - function opposite(dir_t)
  - MAZE_COLS/MAZE_ROWS constants
  - mover state enum
- One combinational sub-module, tile_step: inputs X, Y, dir, and tunnel-row flag; output next X, Y with wrap.

Test Plan:
- Reset, then 8 ticks with dirToMove=L and canMoveL=1 -> pos (12,11), curDir=11, atCenter=1 after tick 8 and 0 during ticks 1–7.
- At centre, dirToMove=U, canMoveU=0, canMoveL=1, curDir=L -> curDir stays L and the ghost moves; with all canMove=0 -> stalled=1 and the position is unchanged after 3 ticks.
- Start at (0,14) heading L with canMoveL=1, then 8 ticks -> pos (27,14). From (27,14) heading R -> pos (0,14).
- forceReverse pulse at subStep=3 heading R -> no change until the centre is reached; at the next centre tick curDir=L (canMoveL=1), even though dirToMove=R.
- Toggle enable=0 across 5 ticks mid-step -> subStep and position are held; after re-enable the move completes after the remaining ticks.
- Assert reset at subStep=5 -> next cycle pos (13,11), subStep=0, curDir=L, atCenter=1.
